tx_block_gearbox: RTL and testbench

- Per-lane transmit gearbox, inverse of the receive block-sync path.
- Accepts 66-bit coded blocks (sync header in the two MSBs) from the TX lane distribution stage.
- Emits a continuous stream of 64-bit words toward the PMA, one word per PMA tick (i_valid).
- Applies back-pressure to upstream once every 33 ticks in steady state (32 blocks → 33 words).
- Also flags blocks with an invalid sync header and upstream underruns.

---
 rtl/tx_block_gearbox.sv | 90 +++++++++
 tb/tb_tx_block_gearbox.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_block_gearbox.sv
// Per-lane transmit gearbox: packs 66-bit coded blocks into a continuous 64-bit word
// stream, back-pressuring upstream whenever the bit buffer cannot take another block.
module tx_block_gearbox #(
    parameter int NB_BLOCK  = 66,
    parameter int NB_WORD   = 64,
    parameter int NB_BUFFER = NB_BLOCK + NB_WORD - 1,
    parameter int NB_FILL   = $clog2(NB_BUFFER + 1)
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [NB_BLOCK-1:0] i_data,
    input  logic                i_data_valid,
    output logic                o_ready,
    output logic [NB_WORD-1:0]  o_data,
    output logic                o_valid,
    output logic                o_sh_invalid,
    output logic                o_underflow
);

    localparam logic [NB_FILL-1:0] C_WORD  = NB_FILL'(NB_WORD);
    localparam logic [NB_FILL-1:0] C_BLOCK = NB_FILL'(NB_BLOCK);

    logic [NB_BUFFER-1:0] r_buffer;
    logic [NB_FILL-1:0]   r_fill;
    logic [NB_WORD-1:0]   r_data;
    logic                 r_valid;
    logic                 r_sh_invalid;
    logic                 r_underflow;

    logic                 w_tick;
    logic                 w_emit;
    logic [NB_FILL-1:0]   w_fill_after;
    logic [NB_BUFFER-1:0] w_shifted;
    logic [NB_BUFFER-1:0] w_insert;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_sh_bad;
    logic [NB_BUFFER-1:0] w_buffer_next;
    logic [NB_FILL-1:0]   w_fill_next;

    assign w_tick       = i_enable & i_valid;
    assign w_emit       = (r_fill >= C_WORD);
    assign w_fill_after = w_emit ? (r_fill - C_WORD) : r_fill;
    assign w_shifted    = w_emit ? (r_buffer << NB_WORD) : r_buffer;

    // Bits below the fill level are always zero, so a new block can simply be ORed in
    // directly beneath the bits that survive this tick's output step.
    assign w_insert      = {i_data, {(NB_BUFFER-NB_BLOCK){1'b0}}} >> w_fill_after;
    assign w_ready       = w_tick & (w_fill_after < C_WORD);
    assign w_accept      = w_ready & i_data_valid;
    assign w_sh_bad      = (i_data[NB_BLOCK-1] == i_data[NB_BLOCK-2]);
    assign w_buffer_next = w_accept ? (w_shifted | w_insert) : w_shifted;
    assign w_fill_next   = w_accept ? (w_fill_after + C_BLOCK) : w_fill_after;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_buffer     <= '0;
            r_fill       <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_sh_invalid <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (i_enable) begin
            if (w_tick) begin
                if (w_emit) begin
                    r_data <= r_buffer[NB_BUFFER-1 -: NB_WORD];
                end
                r_valid      <= w_emit;
                r_buffer     <= w_buffer_next;
                r_fill       <= w_fill_next;
                r_sh_invalid <= w_accept & w_sh_bad;
                r_underflow  <= w_ready & ~i_data_valid;
            end else begin
                r_valid      <= 1'b0;
                r_sh_invalid <= 1'b0;
                r_underflow  <= 1'b0;
            end
        end
    end

    // Pulses are held while disabled, so they are masked here rather than cleared.
    assign o_ready      = w_ready;
    assign o_data       = r_data;
    assign o_valid      = r_valid & i_enable;
    assign o_sh_invalid = r_sh_invalid & i_enable;
    assign o_underflow  = r_underflow & i_enable;

endmodule

// File: tb/tb_tx_block_gearbox.sv
// Scoreboard bench for tx_block_gearbox: a bit-queue reference model predicts every
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_tx_block_gearbox;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        vld;
    logic        dv;
    logic [65:0] din;
    logic        o_ready;
    logic [63:0] o_data;
    logic        o_valid;
    logic        o_sh_invalid;
    logic        o_underflow;

    always #5 clk = ~clk;

    tx_block_gearbox dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_enable     (en),
        .i_valid      (vld),
        .i_data       (din),
        .i_data_valid (dv),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_sh_invalid (o_sh_invalid),
        .o_underflow  (o_underflow)
    );

    typedef struct {
        logic        ready;
        logic        valid;
        logic        sh;
        logic        uf;
        logic [63:0] data;
    } exp_t;

    exp_t        sbq[$];
    bit          bq[$];
    logic        pv;
    logic        ps;
    logic        pu;
    logic [63:0] pd;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One cycle of stimulus; the model predicts this cycle's visible outputs, then
    // advances its bit stream as the coming clock edge should.
    task automatic applyStimulus(input logic e, input logic v, input logic d, input logic [65:0] data);
        exp_t x;
        int   f;
        int   fa;
        bit   tick;
        bit   emit;
        bit   rdy;
        @(posedge clk);
        #1;
        en   = e;
        vld  = v;
        dv   = d;
        din  = data;
        tick = e && v;
        f    = bq.size();
        emit = (f >= 64);
        fa   = emit ? f - 64 : f;
        rdy  = tick && (fa < 64);
        x.ready = rdy;
        x.valid = e & pv;
        x.sh    = e & ps;
        x.uf    = e & pu;
        x.data  = pd;
        sbq.push_back(x);
        if (e) begin
            if (tick) begin
                if (emit) begin
                    for (int i = 63; i >= 0; i--) pd[i] = bq.pop_front();
                end
                pv = emit;
                ps = rdy && d && (data[65] == data[64]);
                pu = rdy && !d;
                if (rdy && d) begin
                    for (int i = 65; i >= 0; i--) bq.push_back(data[i]);
                end
            end else begin
                pv = 1'b0;
                ps = 1'b0;
                pu = 1'b0;
            end
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        vld   = 1'b0;
        dv    = 1'b0;
        din   = '0;
        #1;
        checkOutput("async_rst_valid", {63'b0, o_valid}, 64'd0);
        checkOutput("async_rst_data", o_data, 64'd0);
        bq.delete();
        pv = 1'b0;
        ps = 1'b0;
        pu = 1'b0;
        pd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [65:0] seqBlock(input int n);
        return {2'b01, 64'(n)};
    endfunction

    function automatic logic [65:0] randBlock();
        return {2'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                exp_t x;
                x = sbq.pop_front();
                checkOutput("ready", {63'b0, o_ready}, {63'b0, x.ready});
                checkOutput("valid", {63'b0, o_valid}, {63'b0, x.valid});
                checkOutput("sh_invalid", {63'b0, o_sh_invalid}, {63'b0, x.sh});
                checkOutput("underflow", {63'b0, o_underflow}, {63'b0, x.uf});
                checkOutput("data", o_data, x.data);
            end
        end
    end

    initial begin
        logic [65:0] blk;
        logic [63:0] expw;
        rst_n = 1'b0;
        en    = 1'b0;
        vld   = 1'b0;
        dv    = 1'b0;
        din   = '0;
        pv    = 1'b0;
        ps    = 1'b0;
        pu    = 1'b0;
        pd    = '0;
        doReset();

        for (int n = 1; n <= 70; n++) applyStimulus(1, 1, 1, seqBlock(n));

        doReset();
        blk = 66'h1_FFFF_FFFF_FFFF_FFFF;
        applyStimulus(1, 1, 1, blk);
        applyStimulus(1, 1, 0, '0);
        applyStimulus(1, 0, 0, '0);
        #1;
        checkOutput("first_word_ones", o_data, 64'h7FFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, '0);

        doReset();
        applyStimulus(1, 1, 1, {2'b11, 64'h0123_4567_89AB_CDEF});
        applyStimulus(1, 1, 1, {2'b00, 64'hFEDC_BA98_7654_3210});
        for (int n = 1; n <= 4; n++) applyStimulus(1, 1, 1, seqBlock(n));

        doReset();
        for (int i = 0; i < 80; i++) applyStimulus(1, (i % 2) == 0, 1, 66'h2_A5A5_5A5A_C3C3_3C3C);

        doReset();
        for (int n = 1; n <= 40 && bq.size() != 100; n++) applyStimulus(1, 1, 1, seqBlock(n));
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, seqBlock(99));
        for (int n = 50; n <= 80; n++) applyStimulus(1, 1, 1, seqBlock(n));

        doReset();
        for (int n = 1; n <= 20; n++) applyStimulus(1, 1, 1, randBlock());
        doReset();
        blk = 66'h2_DEAD_BEEF_CAFE_F00D;
        applyStimulus(1, 1, 1, blk);
        applyStimulus(1, 1, 1, seqBlock(7));
        applyStimulus(1, 0, 0, '0);
        #1;
        expw = blk[65:2];
        checkOutput("post_reset_word", o_data, expw);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 10) != 0, ($urandom % 4) != 0, ($urandom % 8) != 0, randBlock());
        end
        applyStimulus(1, 0, 0, '0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
